core_iaddr_trans_tlb: RTL and testbench

Instruction-fetch address translation unit with a real TLB path, successor to the DA/DMW-only translator. It resolves fetch vaddr to paddr via direct-address mode, two DMW windows, or a parametrised fully-associative micro-TLB (uTLB) that refills from the shared TLB through a valid/ready lookup port. It sits between the fetch PC stage and the I-cache tag stage. It produces registered paddr, uncached flag and fetch exceptions (adef/tlbr/pif/ppi).

---
 rtl/core_iaddr_trans_tlb.sv | 244 ++++++++++++++++++++++++
 tb/tb_core_iaddr_trans_tlb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_iaddr_trans_tlb.sv
// rtl/core_iaddr_trans_tlb.sv - fetch address translation: DA, two DMW windows, refilling micro-TLB
package core_iaddr_trans_pkg;
  typedef struct packed {
    logic adef;
    logic tlbr;
    logic pif;
    logic ppi;
    logic ipe;
  } fetch_excp_t;

  typedef struct packed {
    logic [2:0] vseg;
    logic [2:0] pseg;
    logic [1:0] mat;
    logic       plv3;
    logic       plv0;
  } dmw_t;

  typedef struct packed {
    logic       da;
    logic [1:0] datf;
    logic [1:0] plv;
    dmw_t       dmw0;
    dmw_t       dmw1;
    logic [9:0] asid;
  } csr_t;

  typedef struct packed {
    logic        found;
    logic        v;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic [19:0] ppn;
    logic        ps21;
  } tlb_s_resp_t;
endpackage

module core_iaddr_trans_tlb
  import core_iaddr_trans_pkg::*;
#(
  parameter bit ENABLE_TLB   = 1'b1,
  parameter int UTLB_ENTRIES = 4,
  parameter int RESP_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [31:0] vaddr_i,
  input  logic        f_stall_i,
  output logic        ready_o,
  output logic [31:0] paddr_o,
  output logic        uncached_o,
  output fetch_excp_t fetch_excp_o,
  input  csr_t        csr_i,
  input  logic        flush_i,
  output logic [19:0] tlb_req_vppn_o,
  output logic        tlb_req_valid_o,
  input  logic        tlb_req_ready_i,
  input  tlb_s_resp_t tlb_resp_i
);
  localparam int PTR_W = $clog2(UTLB_ENTRIES);
  localparam logic [1:0] LAT = 2'(RESP_LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FAULT} state_e;

  typedef struct packed {
    logic [19:0] tag;
    logic [9:0]  asid;
    logic        v;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic [19:0] ppn;
    logic        ps21;
  } utlb_entry_t;

  state_e                  state_q, state_d;
  logic [19:0]             req_vppn_q, req_vppn_d;
  logic [19:0]             fault_vppn_q, fault_vppn_d;
  logic [1:0]              wait_cnt_q, wait_cnt_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [UTLB_ENTRIES-1:0] valid_q;
  utlb_entry_t             ent_q [UTLB_ENTRIES];
  logic [31:0]             paddr_q;
  logic                    uncached_q;
  fetch_excp_t             excp_q;

  logic             hit;
  logic [PTR_W-1:0] hit_idx;
  logic             dmw0_hit, dmw1_hit;
  logic             miss, fault_sel, ready;
  logic [31:0]      t_paddr;
  logic [1:0]       t_mat;
  fetch_excp_t      t_excp;
  logic             fill_en;
  utlb_entry_t      new_ent;

  // Fully-associative lookup; refill only follows a miss, so at most one entry can match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < UTLB_ENTRIES; i++) begin
      if (!hit && valid_q[i] && (ent_q[i].asid == csr_i.asid) &&
          (ent_q[i].ps21 ? (ent_q[i].tag[19:9] == vaddr_i[31:21])
                         : (ent_q[i].tag == vaddr_i[31:12]))) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  assign dmw0_hit = ((csr_i.dmw0.plv0 && csr_i.plv == 2'd0) || (csr_i.dmw0.plv3 && csr_i.plv == 2'd3)) &&
                    (csr_i.dmw0.vseg == vaddr_i[31:29]);
  assign dmw1_hit = ((csr_i.dmw1.plv0 && csr_i.plv == 2'd0) || (csr_i.dmw1.plv3 && csr_i.plv == 2'd3)) &&
                    (csr_i.dmw1.vseg == vaddr_i[31:29]);

  always_comb begin
    t_paddr   = vaddr_i;
    t_mat     = 2'd0;
    t_excp    = '0;
    miss      = 1'b0;
    fault_sel = 1'b0;
    if (csr_i.da) begin
      t_mat = csr_i.datf;
    end else if (dmw0_hit) begin
      t_paddr = {csr_i.dmw0.pseg, vaddr_i[28:0]};
      t_mat   = csr_i.dmw0.mat;
    end else if (dmw1_hit) begin
      t_paddr = {csr_i.dmw1.pseg, vaddr_i[28:0]};
      t_mat   = csr_i.dmw1.mat;
    end else if (!ENABLE_TLB) begin
      t_excp.adef = 1'b1;
    end else if (hit) begin
      t_paddr    = ent_q[hit_idx].ps21 ? {ent_q[hit_idx].ppn[19:9], vaddr_i[20:0]}
                                       : {ent_q[hit_idx].ppn, vaddr_i[11:0]};
      t_mat      = ent_q[hit_idx].mat;
      t_excp.pif = !ent_q[hit_idx].v;
      t_excp.ppi = ent_q[hit_idx].v && (csr_i.plv > ent_q[hit_idx].plv);
    end else if (state_q == S_FAULT && vaddr_i[31:12] == fault_vppn_q) begin
      fault_sel   = 1'b1;
      t_excp.tlbr = 1'b1;
    end else begin
      miss = (vaddr_i[1:0] == 2'b00);
    end
    // A misaligned fetch completes at once with adef, masking any translation fault.
    if (vaddr_i[1:0] != 2'b00) begin
      t_excp      = '0;
      t_excp.adef = 1'b1;
    end
  end

  assign ready = !(valid_i && miss);

  always_comb begin
    state_d      = state_q;
    req_vppn_d   = req_vppn_q;
    fault_vppn_d = fault_vppn_q;
    wait_cnt_d   = wait_cnt_q;
    ptr_d        = ptr_q;
    fill_en      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (valid_i && miss) begin
          state_d    = S_REQ;
          req_vppn_d = vaddr_i[31:12];
        end
      end
      S_REQ: begin
        if (tlb_req_ready_i) begin
          state_d    = S_WAIT;
          wait_cnt_d = 2'd1;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == LAT) begin
          if (tlb_resp_i.found) begin
            fill_en = 1'b1;
            ptr_d   = ptr_q + PTR_W'(1);
            state_d = S_IDLE;
          end else begin
            fault_vppn_d = req_vppn_q;
            state_d      = S_FAULT;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      S_FAULT: begin
        if (valid_i && fault_sel && !f_stall_i) begin
          state_d = S_IDLE;
        end else if (valid_i && miss) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d = S_IDLE;
      fill_en = 1'b0;
      ptr_d   = ptr_q;
    end
  end

  assign new_ent = '{tag: req_vppn_q, asid: csr_i.asid, v: tlb_resp_i.v, plv: tlb_resp_i.plv,
                     mat: tlb_resp_i.mat, ppn: tlb_resp_i.ppn, ps21: tlb_resp_i.ps21};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_vppn_q   <= '0;
      fault_vppn_q <= '0;
      wait_cnt_q   <= '0;
      ptr_q        <= '0;
      valid_q      <= '0;
      for (int i = 0; i < UTLB_ENTRIES; i++) ent_q[i] <= '0;
      paddr_q      <= '0;
      uncached_q   <= 1'b0;
      excp_q       <= '0;
    end else begin
      state_q      <= state_d;
      req_vppn_q   <= req_vppn_d;
      fault_vppn_q <= fault_vppn_d;
      wait_cnt_q   <= wait_cnt_d;
      ptr_q        <= ptr_d;
      if (flush_i) begin
        valid_q <= '0;
      end else if (fill_en) begin
        valid_q[ptr_q] <= 1'b1;
        ent_q[ptr_q]   <= new_ent;
      end
      if (ready && !f_stall_i) begin
        paddr_q    <= t_paddr;
        uncached_q <= (t_mat != 2'd1);
        excp_q     <= t_excp;
      end
    end
  end

  assign ready_o         = ready;
  assign paddr_o         = paddr_q;
  assign uncached_o      = uncached_q;
  assign fetch_excp_o    = excp_q;
  assign tlb_req_valid_o = (state_q == S_REQ);
  assign tlb_req_vppn_o  = req_vppn_q;
endmodule

// File: tb/tb_core_iaddr_trans_tlb.sv
// tb/tb_core_iaddr_trans_tlb.sv - directed-vector bench for the fetch address translator
module tb_core_iaddr_trans_tlb;
  import core_iaddr_trans_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, valid_i, f_stall_i, flush_i;
  logic        tlb_req_ready_i = 1'b0;
  logic [31:0] vaddr_i;
  csr_t        csr_i;
  logic        ready_o, uncached_o, tlb_req_valid_o;
  logic [31:0] paddr_o;
  fetch_excp_t fetch_excp_o;
  logic [19:0] tlb_req_vppn_o;
  tlb_s_resp_t tlb_resp_i;

  logic        n_ready, n_unc, n_req_valid;
  logic [31:0] n_paddr;
  fetch_excp_t n_excp;
  logic [19:0] n_vppn;

  core_iaddr_trans_tlb dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .vaddr_i(vaddr_i), .f_stall_i(f_stall_i),
    .ready_o(ready_o), .paddr_o(paddr_o), .uncached_o(uncached_o), .fetch_excp_o(fetch_excp_o),
    .csr_i(csr_i), .flush_i(flush_i), .tlb_req_vppn_o(tlb_req_vppn_o),
    .tlb_req_valid_o(tlb_req_valid_o), .tlb_req_ready_i(tlb_req_ready_i), .tlb_resp_i(tlb_resp_i)
  );

  core_iaddr_trans_tlb #(.ENABLE_TLB(1'b0)) dut_notlb (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .vaddr_i(vaddr_i), .f_stall_i(f_stall_i),
    .ready_o(n_ready), .paddr_o(n_paddr), .uncached_o(n_unc), .fetch_excp_o(n_excp),
    .csr_i(csr_i), .flush_i(flush_i), .tlb_req_vppn_o(n_vppn),
    .tlb_req_valid_o(n_req_valid), .tlb_req_ready_i(1'b0), .tlb_resp_i('0)
  );

  // Shared-TLB model: ready after ready_delay request cycles, response one cycle after accept.
  int          ready_delay = 0;
  int          req_wait    = 0;
  int          req_count   = 0;
  int          req_800     = 0;
  logic        resp_vld    = 1'b0;
  tlb_s_resp_t resp_data   = '0;
  logic [19:0] acc_vppn    = '0;
  logic [19:0] flush_ppn   = '0;

  function automatic tlb_s_resp_t pt_lookup(input logic [19:0] vp);
    tlb_s_resp_t r;
    r       = '0;
    r.found = 1'b1;
    r.v     = 1'b1;
    r.plv   = 2'd3;
    r.mat   = 2'd1;
    if (vp == 20'h00402) r.ppn = 20'h12345;
    else if (vp == 20'h00900) begin r.v = 1'b0; r.ppn = 20'h55555; end
    else if (vp == 20'h00A00) begin r.plv = 2'd0; r.mat = 2'd0; r.ppn = 20'h66666; end
    else if (vp == 20'h01200) begin r.ps21 = 1'b1; r.ppn = 20'h7AE55; end
    else if (vp[19:8] == 12'h020) r.ppn = {12'h300, vp[7:0]};
    else if (vp == 20'h03000) r.ppn = flush_ppn;
    else r = '0;
    return r;
  endfunction

  always @(posedge clk) begin
    resp_vld <= 1'b0;
    if (tlb_req_valid_o && tlb_req_ready_i) begin
      resp_vld  <= 1'b1;
      resp_data <= pt_lookup(tlb_req_vppn_o);
      acc_vppn  <= tlb_req_vppn_o;
      req_count <= req_count + 1;
      req_wait  <= 0;
      if (tlb_req_vppn_o == 20'h00800) req_800 <= req_800 + 1;
    end else if (tlb_req_valid_o) begin
      req_wait <= req_wait + 1;
    end else begin
      req_wait <= 0;
    end
  end

  always @(negedge clk) tlb_req_ready_i = tlb_req_valid_o && (req_wait >= ready_delay);
  assign tlb_resp_i = resp_vld ? resp_data : '0;

  int   tlbr_rises = 0;
  logic tlbr_prev  = 1'b0;
  always @(negedge clk) begin
    if (fetch_excp_o.tlbr && !tlbr_prev) tlbr_rises++;
    tlbr_prev = fetch_excp_o.tlbr;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_fetch(input csr_t c, input logic [31:0] va, input int delay,
                          output int low, output int timeout);
    @(negedge clk);
    csr_i       = c;
    vaddr_i     = va;
    valid_i     = 1'b1;
    ready_delay = delay;
    low         = 0;
    timeout     = 0;
    #1;
    while (!ready_o && low < 50) begin
      low++;
      @(negedge clk);
      #1;
    end
    if (!ready_o) timeout = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    @(negedge clk);
    valid_i = 1'b0;
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
  endtask

  typedef struct {
    csr_t        csr;
    logic [31:0] vaddr;
    int          delay;
    logic [31:0] paddr;
    logic        unc;
    logic        chk_unc;
    logic [4:0]  excp;
    int          low;
    int          reqs;
  } vec_t;

  localparam int NV = 12;
  vec_t vec [NV];
  csr_t csr_da, csr_dmw, csr_map, csr_pri;

  initial begin
    int low, to, r0, k;

    csr_da       = '0; csr_da.da = 1'b1; csr_da.datf = 2'd1;
    csr_dmw      = '0; csr_dmw.plv = 2'd0;
    csr_dmw.dmw0 = '{vseg: 3'd5, pseg: 3'd0, mat: 2'd0, plv3: 1'b0, plv0: 1'b1};
    csr_dmw.dmw1 = '{vseg: 3'd4, pseg: 3'd1, mat: 2'd1, plv3: 1'b1, plv0: 1'b0};
    csr_map      = csr_dmw; csr_map.plv = 2'd3;
    csr_pri      = csr_map;
    csr_pri.dmw0 = '{vseg: 3'd4, pseg: 3'd2, mat: 2'd0, plv3: 1'b1, plv0: 1'b0};

    vec[0]  = '{csr_da,  32'h1C00_0000, 0, 32'h1C00_0000, 1'b0, 1'b1, 5'b00000, 0, 0};
    vec[1]  = '{csr_dmw, 32'hA000_1004, 0, 32'h0000_1004, 1'b1, 1'b1, 5'b00000, 0, 0};
    vec[2]  = '{csr_dmw, 32'hA000_1006, 0, 32'h0000_1006, 1'b1, 1'b1, 5'b10000, 0, 0};
    vec[3]  = '{csr_map, 32'h8123_4560, 0, 32'h2123_4560, 1'b0, 1'b1, 5'b00000, 0, 0};
    vec[4]  = '{csr_pri, 32'h8000_0010, 0, 32'h4000_0010, 1'b1, 1'b1, 5'b00000, 0, 0};
    vec[5]  = '{csr_map, 32'h0040_2008, 2, 32'h1234_5008, 1'b0, 1'b1, 5'b00000, 5, 1};
    vec[6]  = '{csr_map, 32'h0040_2ABC, 0, 32'h1234_5ABC, 1'b0, 1'b1, 5'b00000, 0, 0};
    vec[7]  = '{csr_map, 32'h0080_0000, 0, 32'h0080_0000, 1'b0, 1'b0, 5'b01000, 3, 1};
    vec[8]  = '{csr_map, 32'h0090_0004, 0, 32'h5555_5004, 1'b0, 1'b1, 5'b00100, 3, 1};
    vec[9]  = '{csr_map, 32'h00A0_0008, 0, 32'h6666_6008, 1'b1, 1'b1, 5'b00010, 3, 1};
    vec[10] = '{csr_map, 32'h0120_0ABC, 0, 32'h7AE0_0ABC, 1'b0, 1'b1, 5'b00000, 3, 1};
    vec[11] = '{csr_map, 32'h0131_2344, 0, 32'h7AF1_2344, 1'b0, 1'b1, 5'b00000, 0, 0};

    rst_n = 1'b0; valid_i = 1'b0; vaddr_i = '0; f_stall_i = 1'b0; flush_i = 1'b0; csr_i = '0;
    repeat (2) @(negedge clk);
    chk("reset paddr", paddr_o, 32'h0);
    chk("reset uncached", uncached_o, 32'h0);
    chk("reset excp", fetch_excp_o, 32'h0);
    chk("reset req_valid", tlb_req_valid_o, 32'h0);
    chk("reset ready", ready_o, 32'h1);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      r0 = req_count;
      do_fetch(vec[i].csr, vec[i].vaddr, vec[i].delay, low, to);
      chk($sformatf("v%0d timeout", i), to, 0);
      chk($sformatf("v%0d paddr", i), paddr_o, vec[i].paddr);
      if (vec[i].chk_unc) chk($sformatf("v%0d uncached", i), uncached_o, vec[i].unc);
      chk($sformatf("v%0d excp", i), fetch_excp_o, vec[i].excp);
      chk($sformatf("v%0d ready_low_cycles", i), low, vec[i].low);
      chk($sformatf("v%0d requests", i), req_count - r0, vec[i].reqs);
      if (vec[i].reqs != 0) chk($sformatf("v%0d req_vppn", i), acc_vppn, vec[i].vaddr[31:12]);
    end
    chk("tlbr captures", tlbr_rises, 1);
    chk("fault requests", req_800, 1);

    r0 = req_count;
    do_fetch(csr_map, 32'h0040_2ABC, 0, low, to);
    chk("late hit paddr", paddr_o, 32'h1234_5ABC);
    chk("late hit requests", req_count - r0, 0);
    chk("notlb ready", n_ready, 1);
    chk("notlb adef", n_excp, 32'h10);

    do_fetch(csr_da, 32'h1C00_0000, 0, low, to);
    @(negedge clk);
    f_stall_i = 1'b1;
    vaddr_i   = 32'h1C00_1000;
    repeat (2) @(negedge clk);
    chk("stall hold paddr", paddr_o, 32'h1C00_0000);
    f_stall_i = 1'b0;
    @(posedge clk);
    #1;
    chk("stall release paddr", paddr_o, 32'h1C00_1000);

    do_flush();
    for (int p = 0; p < 5; p++) begin
      r0 = req_count;
      do_fetch(csr_map, 32'h0200_0004 + 32'(p) * 32'h1000, 0, low, to);
      chk($sformatf("fill p%0d paddr", p), paddr_o, 32'h3000_0004 + 32'(p) * 32'h1000);
      chk($sformatf("fill p%0d requests", p), req_count - r0, 1);
    end
    for (int p = 1; p < 4; p++) begin
      r0 = req_count;
      do_fetch(csr_map, 32'h0200_0004 + 32'(p) * 32'h1000, 0, low, to);
      chk($sformatf("rehit p%0d low", p), low, 0);
      chk($sformatf("rehit p%0d requests", p), req_count - r0, 0);
    end
    r0 = req_count;
    do_fetch(csr_map, 32'h0200_0004, 0, low, to);
    chk("evicted p0 requests", req_count - r0, 1);
    chk("evicted p0 paddr", paddr_o, 32'h3000_0004);

    do_flush();
    flush_ppn = 20'hAAAAA;
    @(negedge clk);
    csr_i = csr_map; vaddr_i = 32'h0300_0010; valid_i = 1'b1; ready_delay = 0;
    k = 0;
    while (!resp_vld && k < 20) begin @(negedge clk); k++; end
    chk("flush reached wait", resp_vld, 1);
    flush_ppn = 20'hBBBBB;
    flush_i   = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush drops request", tlb_req_valid_o, 0);
    #1;
    k = 0;
    while (!ready_o && k < 50) begin @(negedge clk); #1; k++; end
    chk("flush refetch timeout", ready_o, 1);
    @(posedge clk);
    #1;
    chk("flush refetch paddr", paddr_o, 32'hBBBB_B010);
    r0 = req_count;
    do_fetch(csr_map, 32'h0200_1004, 0, low, to);
    chk("post flush requests", req_count - r0, 1);

    @(negedge clk);
    vaddr_i = 32'h0200_2004;
    k = 0;
    while (!tlb_req_valid_o && k < 20) begin @(negedge clk); k++; end
    rst_n = 1'b0;
    #1;
    chk("midreset req_valid", tlb_req_valid_o, 0);
    chk("midreset paddr", paddr_o, 32'h0);
    chk("midreset excp", fetch_excp_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    k = 0;
    while (!ready_o && k < 50) begin @(negedge clk); #1; k++; end
    @(posedge clk);
    #1;
    chk("after reset paddr", paddr_o, 32'h3000_2004);

    valid_i = 1'b0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
